// File: rtl/vz_dac_spi_tx_if.sv
// rtl/vz_dac_spi_tx_if.sv - drive-value input and serial DAC pin bundle for vz_dac_spi_tx
interface vz_dac_spi_tx_if;
    logic [10:0] i_v_z;
    logic        i_v_z_valid;
    logic        o_dac_sclk;
    logic        o_dac_sync_n;
    logic        o_dac_sdin;
    logic        o_dac_busy;
    logic [11:0] o_dac_code;
    logic [15:0] o_frame_cnt;

    modport master (
        output i_v_z, i_v_z_valid,
        input  o_dac_sclk, o_dac_sync_n, o_dac_sdin, o_dac_busy, o_dac_code, o_frame_cnt
    );

    modport slave (
        input  i_v_z, i_v_z_valid,
        output o_dac_sclk, o_dac_sync_n, o_dac_sdin, o_dac_busy, o_dac_code, o_frame_cnt
    );
endinterface

// File: rtl/vz_dac_spi_tx.sv
// rtl/vz_dac_spi_tx.sv - signed v_z to offset-binary 16-bit SPI frames for a 12-bit serial DAC
module vz_dac_spi_tx #(
    parameter int CLK_DIV     = 4,
    parameter int CS_GAP      = 8,
    parameter int REFRESH_CYC = 50000
) (
    input  logic            i_sys_clk,
    input  logic            i_sys_rst,
    vz_dac_spi_tx_if.slave  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(CS_GAP - 1);
    localparam logic [RW-1:0] REF_MAX = (REFRESH_CYC == 0) ? '0 : RW'(REFRESH_CYC - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_word;
    logic [3:0]    r_bit;
    logic [DW-1:0] r_div;
    logic          r_phase;
    logic [GW-1:0] r_gap;
    logic [11:0]   r_code;
    logic [15:0]   r_frame_cnt;
    logic          r_pending;
    logic [RW-1:0] r_refresh;

    logic [11:0]   w_code;
    logic          w_refresh_hit;
    logic          w_bit_end;
    logic          w_busy;
    logic          w_launch;
    logic [11:0]   w_launch_code;
    logic          w_sclk;
    logic          w_sync_n;
    logic          w_sdin;

    assign w_code        = {~bus.i_v_z[10], bus.i_v_z};
    assign w_refresh_hit = (REFRESH_CYC != 0) && (r_refresh == REF_MAX);
    assign w_bit_end     = (r_state == ST_SHIFT) && r_phase && (r_div == DIV_MAX);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_SHIFT;
            ST_IDLE:  if (w_launch) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_bit_end && (r_bit == 4'd15)) w_state_nxt = ST_GAP;
            ST_GAP:   if (r_gap == GAP_MAX) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    // Pins decode straight from state; the final SCLK rise coincides with sync_n release.
    always_comb begin
        w_launch      = 1'b0;
        w_launch_code = w_code;
        w_busy        = (r_state == ST_SHIFT) || (r_state == ST_GAP);
        w_sync_n      = (r_state != ST_SHIFT);
        w_sclk        = (r_state != ST_SHIFT) || !r_phase;
        w_sdin        = (r_state == ST_SHIFT) && r_word[15];
        if (r_state == ST_INIT) begin
            w_launch      = 1'b1;
            w_launch_code = 12'h800;
        end else if (r_state == ST_IDLE) begin
            w_launch = bus.i_v_z_valid && ((w_code != r_code) || r_pending || w_refresh_hit);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_word      <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_phase     <= 1'b0;
            r_gap       <= '0;
            r_code      <= 12'h800;
            r_frame_cnt <= '0;
            r_pending   <= 1'b0;
            r_refresh   <= '0;
        end else begin
            if (r_state == ST_SHIFT) begin
                if (r_div == DIV_MAX) begin
                    r_div   <= '0;
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_bit  <= r_bit + 4'd1;
                        r_word <= {r_word[14:0], 1'b0};
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end else begin
                r_div   <= '0;
                r_phase <= 1'b0;
                r_bit   <= '0;
            end

            if (r_state == ST_GAP) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            if (w_launch) begin
                r_word      <= {2'b00, w_launch_code, 2'b00};
                r_code      <= w_launch_code;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_pending   <= 1'b0;
                r_refresh   <= '0;
            end else begin
                // r_code holds the in-flight code while busy, so any difference means a newer value.
                if (w_busy && bus.i_v_z_valid && (w_code != r_code)) begin
                    r_pending <= 1'b1;
                end
                if (!w_busy && (r_refresh != REF_MAX)) begin
                    r_refresh <= r_refresh + 1'b1;
                end
            end
        end
    end

    assign bus.o_dac_sclk   = w_sclk;
    assign bus.o_dac_sync_n = w_sync_n;
    assign bus.o_dac_sdin   = w_sdin;
    assign bus.o_dac_busy   = w_busy;
    assign bus.o_dac_code   = r_code;
    assign bus.o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_vz_dac_spi_tx.sv
// tb/tb_vz_dac_spi_tx.sv - table and scoreboard bench for vz_dac_spi_tx
module tb_vz_dac_spi_tx;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;

    typedef struct {
        logic [10:0] v_z;
        logic        valid;
        logic        frame;
        logic [15:0] word;
        logic [11:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vz_dac_spi_tx_if a_if ();
    vz_dac_spi_tx_if b_if ();

    vz_dac_spi_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .REFRESH_CYC(0)) u_dut_a (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (a_if)
    );

    vz_dac_spi_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .REFRESH_CYC(300)) u_dut_b (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (b_if)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor and scoreboard for DUT A: deserialise on SCLK falls while sync_n is low.
    logic [15:0] exp_q[$];
    logic [15:0] m_shreg = '0;
    int  m_nfall = 0, m_low = 0;
    bit  m_in = 0;
    logic m_prev_sclk = 1'b1;
    int  a_frames = 0, a_t_last = 0, a_t_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_in = 0;
            m_prev_sclk = 1'b1;
        end else begin
            if (!a_if.o_dac_sync_n) begin
                if (!m_in) begin
                    m_in = 1; m_nfall = 0; m_low = 0; m_shreg = '0;
                    a_t_prev = a_t_last; a_t_last = cyc;
                end
                m_low++;
                if (m_prev_sclk && !a_if.o_dac_sclk) begin
                    m_shreg = {m_shreg[14:0], a_if.o_dac_sdin};
                    m_nfall++;
                end
            end else if (m_in) begin
                m_in = 0;
                a_frames++;
                check("sclk_falls", m_nfall, 16);
                check("sync_low_cycles", m_low, 32 * CLK_DIV);
                check("sdin_at_sync_rise", a_if.o_dac_sdin, 0);
                check("sclk_at_sync_rise", a_if.o_dac_sclk, 1);
                if (exp_q.size() > 0) begin
                    check("frame_word", m_shreg, exp_q.pop_front());
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got word 0x%04h, expected no frame", m_shreg);
                end
            end
            m_prev_sclk = a_if.o_dac_sclk;
        end
    end

    int   b_times[$];
    logic b_prev_sync = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            b_times.delete();
            b_prev_sync = 1'b1;
        end else begin
            if (b_prev_sync && !b_if.o_dac_sync_n) b_times.push_back(cyc);
            b_prev_sync = b_if.o_dac_sync_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_a_frames(input int target, input int budget, input string name);
        int n = 0;
        while (a_frames < target && n < budget) begin @(negedge clk); n++; end
        check(name, a_frames >= target, 1);
    endtask

    task automatic wait_a_idle(input int budget);
        int n = 0;
        while (a_if.o_dac_busy && n < budget) begin @(negedge clk); n++; end
        check("wait_idle", a_if.o_dac_busy, 0);
    endtask

    task automatic wait_a_sync_low(input int budget);
        int n = 0;
        while (a_if.o_dac_sync_n && n < budget) begin @(negedge clk); n++; end
        check("wait_sync_low", a_if.o_dac_sync_n, 0);
    endtask

    task automatic wait_b_falls(input int target, input int budget, input string name);
        int n = 0;
        while (b_times.size() < target && n < budget) begin @(negedge clk); n++; end
        check(name, b_times.size() >= target, 1);
    endtask

    int a_exp   = 0;
    int exp_cnt = 0;

    initial begin
        vec_t tbl[8];
        int n;
        tbl[0] = '{11'h180, 1'b0, 1'b0, 16'h0000, 12'h800};
        tbl[1] = '{11'h180, 1'b1, 1'b1, 16'h2600, 12'h980};
        tbl[2] = '{11'h680, 1'b1, 1'b1, 16'h1A00, 12'h680};
        tbl[3] = '{11'h400, 1'b1, 1'b1, 16'h1000, 12'h400};
        tbl[4] = '{11'h3FF, 1'b1, 1'b1, 16'h2FFC, 12'hBFF};
        tbl[5] = '{11'h3FF, 1'b1, 1'b0, 16'h0000, 12'hBFF};
        tbl[6] = '{11'h000, 1'b1, 1'b1, 16'h2000, 12'h800};
        tbl[7] = '{11'h7C0, 1'b0, 1'b0, 16'h0000, 12'h800};

        a_if.i_v_z = '0; a_if.i_v_z_valid = 1'b0;
        b_if.i_v_z = '0; b_if.i_v_z_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", a_if.o_dac_sclk, 1);
        check("rst_sync_n", a_if.o_dac_sync_n, 1);
        check("rst_sdin", a_if.o_dac_sdin, 0);
        check("rst_busy", a_if.o_dac_busy, 0);
        check("rst_code", a_if.o_dac_code, 12'h800);
        check("rst_frame_cnt", a_if.o_frame_cnt, 0);

        exp_q.push_back(16'h2000); a_exp = 1; exp_cnt = 1;
        step(); rst = 1'b0;
        wait_a_frames(a_exp, 300, "init_frame");
        wait_a_idle(50);
        check("init_frame_cnt", a_if.o_frame_cnt, 1);
        check("init_code", a_if.o_dac_code, 12'h800);

        for (int i = 0; i < 8; i++) begin
            step();
            a_if.i_v_z = tbl[i].v_z;
            a_if.i_v_z_valid = tbl[i].valid;
            if (tbl[i].frame) begin
                exp_q.push_back(tbl[i].word); a_exp++; exp_cnt++;
                wait_a_frames(a_exp, 300, "vec_frame");
                wait_a_idle(50);
            end
            repeat (200) @(negedge clk);
            check("vec_frames_seen", a_frames, a_exp);
            check("vec_code", a_if.o_dac_code, tbl[i].code);
            check("vec_frame_cnt", a_if.o_frame_cnt, exp_cnt);
        end

        // Latest value wins for changes during a frame, with one follow-up frame.
        step(); a_if.i_v_z = 11'h180; a_if.i_v_z_valid = 1'b1;
        exp_q.push_back(16'h2600);
        wait_a_sync_low(20);
        repeat (20) @(negedge clk); step(); a_if.i_v_z = 11'h040;
        repeat (20) @(negedge clk); step(); a_if.i_v_z = 11'h7C0;
        exp_q.push_back(16'h1F00); a_exp += 2; exp_cnt += 2;
        wait_a_frames(a_exp, 500, "busy_change_frames");
        wait_a_idle(50);
        check("launch_to_launch", a_t_last - a_t_prev, 1 + 32 * CLK_DIV + CS_GAP);
        repeat (300) @(negedge clk);
        check("busy_change_no_extra", a_frames, a_exp);
        check("busy_change_code", a_if.o_dac_code, 12'h7C0);

        // Returning to the in-flight value still forces one resend.
        step(); a_if.i_v_z = 11'h100;
        exp_q.push_back(16'h2400);
        wait_a_sync_low(20);
        repeat (20) @(negedge clk); step(); a_if.i_v_z = 11'h200;
        repeat (20) @(negedge clk); step(); a_if.i_v_z = 11'h100;
        exp_q.push_back(16'h2400); a_exp += 2; exp_cnt += 2;
        wait_a_frames(a_exp, 500, "return_frames");
        wait_a_idle(50);
        repeat (300) @(negedge clk);
        check("return_no_extra", a_frames, a_exp);
        check("return_code", a_if.o_dac_code, 12'h900);
        check("return_frame_cnt", a_if.o_frame_cnt, exp_cnt);

        // Reset part-way through a frame.
        step(); a_if.i_v_z = 11'h180;
        n = 0;
        while (!(m_in && m_nfall == 7) && n < 300) begin @(negedge clk); n++; end
        check("reach_bit7", m_nfall, 7);
        step(); rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_sync_n", a_if.o_dac_sync_n, 1);
        check("midrst_sclk", a_if.o_dac_sclk, 1);
        check("midrst_sdin", a_if.o_dac_sdin, 0);
        check("midrst_busy", a_if.o_dac_busy, 0);
        check("midrst_frame_cnt", a_if.o_frame_cnt, 0);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h2600);
        a_exp += 2; exp_cnt = 2;
        step(); rst = 1'b0;
        wait_a_frames(a_exp, 600, "post_rst_frames");
        wait_a_idle(50);
        check("post_rst_frame_cnt", a_if.o_frame_cnt, exp_cnt);
        check("post_rst_code", a_if.o_dac_code, 12'h980);

        // Periodic refresh on the REFRESH_CYC=300 instance.
        wait_b_falls(1, 300, "b_init_frame");
        step(); b_if.i_v_z = 11'h180; b_if.i_v_z_valid = 1'b1;
        wait_b_falls(2, 200, "b_change_frame");
        wait_b_falls(4, 1200, "b_refresh_frames");
        if (b_times.size() >= 4) begin
            check("refresh_interval_1", b_times[2] - b_times[1], 137 + 299);
            check("refresh_interval_2", b_times[3] - b_times[2], 137 + 299);
        end
        check("b_code", b_if.o_dac_code, 12'h980);
        check("b_frame_cnt", b_if.o_frame_cnt, 4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
